d_phy_hs_receiver: RTL
======================

// Module: d_phy_hs_receiver
// PURPOSE
//  Receive-side counterpart of the D-PHY lane driver: samples the single-lane Dp/Dn pair,
//  tracks the LP entry sequence LP-11 -> LP-01 -> LP-00, and enters HS mode.
//  In HS mode it hunts for sync byte 0xB8, deserialises LSB-first bytes and strobes them
//  out. It returns to LP on LP-11. Sits at the far end of the lane in loopback/system benches.
// PARAMETERS
//  LP_FILT       2   consecutive identical samples needed before an LP state is accepted
//  SYNC_TIMEOUT  64  HS bits allowed in HS_SYNC before sync is declared lost
//  SYNC_BYTE     8'hB8  HS leader pattern
// PORTS
//  TX_DDR_clk     in   1  bit clock; one HS bit sampled per rising edge
//  TX_rst         in   1  asynchronous, active-high reset
//  Dp, Dn         in   1  lane pair
//  RX_BYTE_HS     out  8  received byte, valid with RX_VALID, held until next byte
//  RX_VALID       out  1  one-cycle strobe per complete byte
//  RX_ACTIVE      out  1  high from sync detect until HS exit
//  RX_SYNC_ERR    out  1  one-cycle pulse: sync timeout, or LP-11 seen in HS_SYNC
//  RX_LP_STATE    out  2  filtered {Dp,Dn}
//  RX_STATE       out  3  FSM state encoding below
// BEHAVIOUR
//  Reset: all outputs 0 except RX_LP_STATE=2'b11; state INIT; shift reg and counters cleared.
//   Reset mid-burst behaves the same: remaining HS bits are ignored until a filtered LP-11.
//  LP filter: RX_LP_STATE updates only after {Dp,Dn} holds the same value for LP_FILT samples.
//   The filter runs in every state.
//  HS bit decode uses raw samples: (1,0)=1, (0,1)=0, (0,0)=ignored (no shift, no count),
//   (1,1)=HS exit, acted on immediately with no filtering.
//  FSM (RX_STATE encoding):
//   INIT 0      : filtered 11 -> STOP
//   STOP 1      : filtered 01 -> HS_RQST; filtered 10 or 00 -> INIT (escape unsupported)
//   HS_RQST 2   : filtered 00 -> BRIDGE; filtered 11 -> STOP; filtered 10 -> INIT
//   BRIDGE 3    : raw complementary -> HS_SYNC; that sample is the first shifted bit. raw 11 -> STOP
//   HS_SYNC 4   : sr <= {bit, sr[7:1]}; sync_cnt++
//                 - next sr == SYNC_BYTE -> HS_DATA, bit_cnt=0, RX_ACTIVE=1 on the next edge
//                 - sync_cnt reaches SYNC_TIMEOUT -> RX_SYNC_ERR pulse, HS_IGNORE
//                 - raw 11 -> RX_SYNC_ERR pulse, STOP
//   HS_DATA 5   : shift each decoded bit; bit_cnt wraps 7 -> 0
//                 - on the 8th bit: RX_BYTE_HS <= next sr and RX_VALID=1, both on the next edge
//                   (latency is 1 cycle after the last bit's sampling edge)
//                 - raw 11 -> STOP, RX_ACTIVE=0 on the next edge, partial byte discarded, no strobe
//   HS_IGNORE 6 : wait for raw 11 -> STOP; no strobes
//  Bit order: LSB first. The sync bits in time order are 0,0,0,1,1,1,0,1.
//  Leading HS-zero bits are absorbed by the sync hunt.
//  Trailer: complete bytes are always emitted. Trailer stripping belongs to the protocol layer.
//  sync_cnt is wide enough for SYNC_TIMEOUT and is cleared on entry to HS_SYNC.
//  RX_VALID max rate: one pulse per 8 cycles.
//  After HS_DATA -> STOP a new burst needs the full LP-01/LP-00 sequence.
// TESTING
//  1 Reset; LP-11 x4, LP-01 x4, LP-00 x4; HS: 8 zeros, B8, A5, 3C; then LP-11
//    -> exactly two RX_VALID pulses, bytes A5 then 3C; RX_ACTIVE rises 1 cycle after the
//       sync's last bit and falls 1 cycle after the first 11 sample; RX_STATE ends at 1.
//  2 In STOP, drive a 1-cycle LP-01 glitch -> RX_LP_STATE stays 11, RX_STATE stays 1,
//    no HS entry.
//  3 After LP-00, send 70 zero bits -> one RX_SYNC_ERR pulse at bit 64, RX_STATE=6,
//    no RX_VALID; LP-11 -> RX_STATE=1.
//  4 Sync, byte 5A, 3 extra bits, then LP-11 -> one RX_VALID (5A) only; partial dropped.
//  5 Assert TX_rst mid-byte in HS_DATA -> outputs 0 asynchronously, RX_STATE=0;
//    HS bits after release give no strobe until LP-11.
//  6 Two back-to-back bursts (00..03, then FF) separated by LP-11 x4 -> five strobes in order,
//    no RX_SYNC_ERR.

Source files
------------

// File: rtl/d_phy_hs_receiver.sv
// D-PHY single-lane HS receiver.
// It filters the LP levels and follows the LP-11 -> LP-01 -> LP-00 entry sequence.
// In HS mode it hunts for the sync byte, then deserialises LSB-first bytes.
// A raw LP-11 sample ends the burst and returns the receiver to STOP.
module d_phy_hs_receiver #(
   parameter int         LP_FILT      = 2,
   parameter int         SYNC_TIMEOUT = 64,
   parameter logic [7:0] SYNC_BYTE    = 8'hB8
) (
   input  logic       TX_DDR_clk,
   input  logic       TX_rst,
   input  logic       Dp,
   input  logic       Dn,
   output logic [7:0] RX_BYTE_HS,
   output logic       RX_VALID,
   output logic       RX_ACTIVE,
   output logic       RX_SYNC_ERR,
   output logic [1:0] RX_LP_STATE,
   output logic [2:0] RX_STATE
);

   localparam int FW = $clog2(LP_FILT + 1);
   localparam int SW = $clog2(SYNC_TIMEOUT + 1);

   typedef enum logic [2:0] {
      ST_INIT      = 3'd0,
      ST_STOP      = 3'd1,
      ST_HS_RQST   = 3'd2,
      ST_BRIDGE    = 3'd3,
      ST_HS_SYNC   = 3'd4,
      ST_HS_DATA   = 3'd5,
      ST_HS_IGNORE = 3'd6
   } state_t;

   state_t        r_state, w_state_nxt;
   logic [1:0]    r_lp_prev, r_lp_state;
   logic [FW-1:0] r_lp_cnt, w_lp_cnt_nxt;
   logic          w_lp_same, w_lp_evt;
   logic [7:0]    r_sr, w_sr_nxt, w_sr_shift;
   logic [SW-1:0] r_sync_cnt, w_sync_cnt_nxt;
   logic [2:0]    r_bit_cnt, w_bit_cnt_nxt;
   logic [7:0]    r_byte, w_byte_nxt;
   logic          r_valid, w_valid_nxt;
   logic          r_err, w_err_nxt;
   logic          r_active, w_active_nxt;
   logic [1:0]    w_raw;
   logic          w_is_11, w_is_bit, w_bit;

   assign w_raw      = {Dp, Dn};
   assign w_is_11    = (w_raw == 2'b11);
   assign w_is_bit   = Dp ^ Dn;
   assign w_bit      = Dp;
   assign w_sr_shift = {w_bit, r_sr[7:1]};

   // LP filter: count how long the raw level has been stable.
   // w_lp_evt fires once, on the sample where a level becomes accepted.
   // The LP FSM states react only to that event. A stale filtered level left over
   // from HS data therefore cannot trigger a transition after HS exit.
   always_comb begin
      w_lp_same    = (w_raw == r_lp_prev);
      w_lp_cnt_nxt = FW'(1);
      if (w_lp_same)
         w_lp_cnt_nxt = (r_lp_cnt == FW'(LP_FILT)) ? r_lp_cnt : r_lp_cnt + FW'(1);
      w_lp_evt = (w_lp_cnt_nxt == FW'(LP_FILT)) && !(w_lp_same && r_lp_cnt == FW'(LP_FILT));
   end

   // Filter state registers; the filter runs in every FSM state.
   always_ff @(posedge TX_DDR_clk or posedge TX_rst) begin
      if (TX_rst) begin
         r_lp_prev  <= 2'b11;
         r_lp_cnt   <= '0;
         r_lp_state <= 2'b11;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so that every register
         // samples pre-edge values, whatever order the statements appear in.
         r_lp_prev <= w_raw;
         r_lp_cnt  <= w_lp_cnt_nxt;
         if (w_lp_evt)
            r_lp_state <= w_raw;
      end
   end

   // FSM state register.
   always_ff @(posedge TX_DDR_clk or posedge TX_rst) begin
      if (TX_rst) r_state <= ST_INIT;
      else        r_state <= w_state_nxt;
   end

   // Next-state and datapath decisions.
   always_comb begin
      // NOTE: every signal gets a default before the case statement,
      // so no path through this block can infer a latch.
      w_state_nxt    = r_state;
      w_sr_nxt       = r_sr;
      w_sync_cnt_nxt = r_sync_cnt;
      w_bit_cnt_nxt  = r_bit_cnt;
      w_byte_nxt     = r_byte;
      w_valid_nxt    = 1'b0;
      w_err_nxt      = 1'b0;
      w_active_nxt   = r_active;
      case (r_state)
         ST_INIT: begin
            if (w_lp_evt && w_raw == 2'b11) w_state_nxt = ST_STOP;
         end
         ST_STOP: begin
            if (w_lp_evt) begin
               case (w_raw)
                  2'b01:   w_state_nxt = ST_HS_RQST;
                  2'b10,
                  2'b00:   w_state_nxt = ST_INIT;
                  default: w_state_nxt = ST_STOP;
               endcase
            end
         end
         ST_HS_RQST: begin
            if (w_lp_evt) begin
               case (w_raw)
                  2'b00:   w_state_nxt = ST_BRIDGE;
                  2'b11:   w_state_nxt = ST_STOP;
                  2'b10:   w_state_nxt = ST_INIT;
                  default: w_state_nxt = ST_HS_RQST;
               endcase
            end
         end
         ST_BRIDGE: begin
            if (w_is_11) begin
               w_state_nxt = ST_STOP;
            end else if (w_is_bit) begin
               // The first complementary sample is already a data bit.
               // It is shifted into a cleared register, and the sync count starts at one.
               w_state_nxt    = ST_HS_SYNC;
               w_sr_nxt       = {w_bit, 7'd0};
               w_sync_cnt_nxt = SW'(1);
            end
         end
         ST_HS_SYNC: begin
            if (w_is_11) begin
               w_err_nxt   = 1'b1;
               w_state_nxt = ST_STOP;
            end else if (w_is_bit) begin
               w_sr_nxt       = w_sr_shift;
               w_sync_cnt_nxt = r_sync_cnt + SW'(1);
               if (w_sr_shift == SYNC_BYTE) begin
                  w_state_nxt   = ST_HS_DATA;
                  w_bit_cnt_nxt = 3'd0;
                  w_active_nxt  = 1'b1;
               end else if (w_sync_cnt_nxt == SW'(SYNC_TIMEOUT)) begin
                  w_err_nxt   = 1'b1;
                  w_state_nxt = ST_HS_IGNORE;
               end
            end
         end
         ST_HS_DATA: begin
            if (w_is_11) begin
               w_state_nxt   = ST_STOP;
               w_active_nxt  = 1'b0;
               w_bit_cnt_nxt = 3'd0;
            end else if (w_is_bit) begin
               w_sr_nxt      = w_sr_shift;
               w_bit_cnt_nxt = r_bit_cnt + 3'd1;
               if (r_bit_cnt == 3'd7) begin
                  w_byte_nxt  = w_sr_shift;
                  w_valid_nxt = 1'b1;
               end
            end
         end
         ST_HS_IGNORE: begin
            if (w_is_11) w_state_nxt = ST_STOP;
         end
         default: w_state_nxt = ST_INIT;
      endcase
   end

   // Datapath and registered outputs.
   always_ff @(posedge TX_DDR_clk or posedge TX_rst) begin
      if (TX_rst) begin
         r_sr       <= '0;
         r_sync_cnt <= '0;
         r_bit_cnt  <= '0;
         r_byte     <= '0;
         r_valid    <= 1'b0;
         r_err      <= 1'b0;
         r_active   <= 1'b0;
      end else begin
         r_sr       <= w_sr_nxt;
         r_sync_cnt <= w_sync_cnt_nxt;
         r_bit_cnt  <= w_bit_cnt_nxt;
         r_byte     <= w_byte_nxt;
         r_valid    <= w_valid_nxt;
         r_err      <= w_err_nxt;
         r_active   <= w_active_nxt;
      end
   end

   assign RX_BYTE_HS  = r_byte;
   assign RX_VALID    = r_valid;
   assign RX_ACTIVE   = r_active;
   assign RX_SYNC_ERR = r_err;
   assign RX_LP_STATE = r_lp_state;
   assign RX_STATE    = r_state;

endmodule
